// File: rtl/cache_pkg.sv
// Shared definitions for the set-associative write-through cache controller:
// FSM encoding, parameter defaults and address-field width helpers.
package cache_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RD_MISS  = 2'd1,
      WR_THRU  = 2'd2,
      FLUSHING = 2'd3
   } state_t;

   localparam int ADDR_W_DEF     = 32;
   localparam int DATA_W_DEF     = 32;
   localparam int LINE_WORDS_DEF = 2;
   localparam int SETS_DEF       = 64;
   localparam int WAYS_DEF       = 2;

   function automatic int off_w(input int data_w);
      return $clog2(data_w / 8);
   endfunction

   function automatic int word_w(input int line_words);
      return $clog2(line_words);
   endfunction

   function automatic int idx_w(input int sets);
      return $clog2(sets);
   endfunction

   function automatic int tag_w(input int addr_w, input int data_w, input int line_words, input int sets);
      return addr_w - off_w(data_w) - word_w(line_words) - idx_w(sets);
   endfunction

   // Storage width for a field that may legitimately be zero bits wide.
   function automatic int bits1(input int n);
      return (n < 1) ? 1 : n;
   endfunction

endpackage

// File: rtl/cache_lru.sv
// Per-set age-based LRU bookkeeping and victim selection.
// Victim is the lowest invalid way, otherwise the oldest way.
module cache_lru
   import cache_pkg::*;
#(
   parameter int WAYS = WAYS_DEF,
   parameter int SETS = SETS_DEF,
   localparam int IB  = bits1(idx_w(SETS)),
   localparam int WB  = bits1($clog2(WAYS))
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [IB-1:0]   i_idx,
   input  logic [WAYS-1:0] i_valid,
   input  logic            i_touch_en,
   input  logic [WB-1:0]   i_touch_way,
   input  logic            i_clr_en,
   input  logic [IB-1:0]   i_clr_idx,
   output logic [WB-1:0]   o_victim
);

   generate
      if (WAYS == 1) begin : g_direct
         assign o_victim = '0;
      end else begin : g_lru
         localparam int AGE_W = $clog2(WAYS);

         logic [AGE_W-1:0] r_age [SETS][WAYS];
         logic [AGE_W-1:0] w_max;
         logic [WB-1:0]    w_victim;
         logic             w_found;

         always_comb begin
            w_found  = 1'b0;
            w_victim = '0;
            w_max    = r_age[i_idx][0];
            for (int w = 0; w < WAYS; w++) begin
               if (!i_valid[w] && !w_found) begin
                  w_victim = WB'(w);
                  w_found  = 1'b1;
               end
            end
            if (!w_found) begin
               for (int w = 1; w < WAYS; w++) begin
                  if (r_age[i_idx][w] > w_max) begin
                     w_max    = r_age[i_idx][w];
                     w_victim = WB'(w);
                  end
               end
            end
         end

         assign o_victim = w_victim;

         // Ways no older than the touched one age by one (saturating), so
         // equal ages after reset or flush still separate on first use.
         always_ff @(posedge clk) begin
            if (rst) begin
               for (int s = 0; s < SETS; s++)
                  for (int w = 0; w < WAYS; w++)
                     r_age[s][w] <= '0;
            end else begin
               if (i_clr_en) begin
                  for (int w = 0; w < WAYS; w++)
                     r_age[i_clr_idx][w] <= '0;
               end
               if (i_touch_en) begin
                  for (int w = 0; w < WAYS; w++) begin
                     if (w == int'(i_touch_way))
                        r_age[i_idx][w] <= '0;
                     else if ((r_age[i_idx][w] <= r_age[i_idx][i_touch_way]) && (r_age[i_idx][w] != '1))
                        r_age[i_idx][w] <= r_age[i_idx][w] + AGE_W'(1);
                  end
               end
            end
         end
      end
   endgenerate

endmodule

// File: rtl/assoc_cache_ctrl.sv
// Set-associative, write-through, no-write-allocate data cache controller
// with zero-wait read hits, line fills from SRAM and a one-set-per-cycle flush.
module assoc_cache_ctrl
   import cache_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int LINE_WORDS = LINE_WORDS_DEF,
   parameter int SETS       = SETS_DEF,
   parameter int WAYS       = WAYS_DEF
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [ADDR_W-1:0]            addr,
   input  logic [DATA_W-1:0]            write_data,
   input  logic                         MEM_R_EN,
   input  logic                         MEM_W_EN,
   input  logic                         flush,
   output logic [DATA_W-1:0]            read_data,
   output logic                         ready,
   output logic [ADDR_W-1:0]            sram_addr,
   output logic [DATA_W-1:0]            sram_write_data,
   output logic                         sram_write_en,
   output logic                         sram_read_en,
   input  logic [DATA_W*LINE_WORDS-1:0] sram_read_data,
   input  logic                         sram_ready,
   output logic [31:0]                  hit_count,
   output logic [31:0]                  miss_count
);

   localparam int OFF_W  = off_w(DATA_W);
   localparam int WORD_W = word_w(LINE_WORDS);
   localparam int IDX_W  = idx_w(SETS);
   localparam int TAG_W  = tag_w(ADDR_W, DATA_W, LINE_WORDS, SETS);
   localparam int WB     = bits1(WORD_W);
   localparam int IB     = bits1(IDX_W);
   localparam int WAY_B  = bits1($clog2(WAYS));
   localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_WORDS * (DATA_W / 8) - 1);

   state_t r_state, w_next;

   logic [WAYS-1:0]   r_valid [SETS];
   logic [TAG_W-1:0]  r_tag   [SETS][WAYS];
   logic [DATA_W-1:0] r_data  [SETS][WAYS][LINE_WORDS];

   logic [IB-1:0]     r_flush_idx;
   logic              r_flush_pend;
   logic [31:0]       r_hit_cnt, r_miss_cnt;

   logic [WB-1:0]     w_word;
   logic [IB-1:0]     w_idx;
   logic [TAG_W-1:0]  w_tag;
   logic              w_hit;
   logic [WAY_B-1:0]  w_hit_way, w_victim, w_touch_way;
   logic [DATA_W-1:0] w_hit_data, w_fill_word;
   logic              w_touch_en, w_fill_en, w_wr_hit_en, w_clr_en, w_flush_start;
   logic              w_hit_inc, w_miss_inc;

   assign w_word = WB'((addr >> OFF_W) & ADDR_W'(LINE_WORDS - 1));
   assign w_idx  = IB'((addr >> (OFF_W + WORD_W)) & ADDR_W'(SETS - 1));
   assign w_tag  = TAG_W'(addr >> (OFF_W + WORD_W + IDX_W));

   always_comb begin
      w_hit     = 1'b0;
      w_hit_way = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
            w_hit     = 1'b1;
            w_hit_way = WAY_B'(w);
         end
      end
   end

   assign w_hit_data  = r_data[w_idx][w_hit_way][w_word];
   assign w_fill_word = sram_read_data[int'(w_word)*DATA_W +: DATA_W];

   cache_lru #(
      .WAYS (WAYS),
      .SETS (SETS)
   ) u_lru (
      .clk         (clk),
      .rst         (rst),
      .i_idx       (w_idx),
      .i_valid     (r_valid[w_idx]),
      .i_touch_en  (w_touch_en),
      .i_touch_way (w_touch_way),
      .i_clr_en    (w_clr_en),
      .i_clr_idx   (r_flush_idx),
      .o_victim    (w_victim)
   );

   always_comb begin
      w_next          = r_state;
      ready           = 1'b0;
      read_data       = '0;
      sram_read_en    = 1'b0;
      sram_write_en   = 1'b0;
      sram_addr       = '0;
      sram_write_data = '0;
      w_touch_en      = 1'b0;
      w_touch_way     = '0;
      w_fill_en       = 1'b0;
      w_wr_hit_en     = 1'b0;
      w_hit_inc       = 1'b0;
      w_miss_inc      = 1'b0;
      w_clr_en        = 1'b0;
      w_flush_start   = 1'b0;
      case (r_state)
         IDLE: begin
            // A store wins when both enables are raised together.
            if (MEM_W_EN) begin
               w_next      = WR_THRU;
               w_wr_hit_en = w_hit;
               w_touch_en  = w_hit;
               w_touch_way = w_hit_way;
            end else if (MEM_R_EN) begin
               if (w_hit) begin
                  ready       = 1'b1;
                  read_data   = w_hit_data;
                  w_hit_inc   = 1'b1;
                  w_touch_en  = 1'b1;
                  w_touch_way = w_hit_way;
               end else begin
                  w_next = RD_MISS;
               end
            end else begin
               ready = 1'b1;
               if (flush || r_flush_pend) begin
                  w_next        = FLUSHING;
                  w_flush_start = 1'b1;
               end
            end
         end
         RD_MISS: begin
            sram_read_en = 1'b1;
            sram_addr    = addr & ~LINE_MASK;
            if (sram_ready) begin
               ready       = 1'b1;
               read_data   = w_fill_word;
               w_fill_en   = 1'b1;
               w_miss_inc  = 1'b1;
               w_touch_en  = 1'b1;
               w_touch_way = w_victim;
               w_next      = IDLE;
            end
         end
         WR_THRU: begin
            sram_write_en   = 1'b1;
            sram_addr       = addr;
            sram_write_data = write_data;
            if (sram_ready) begin
               ready  = 1'b1;
               w_next = IDLE;
            end
         end
         FLUSHING: begin
            w_clr_en = 1'b1;
            if (r_flush_idx == IB'(SETS - 1))
               w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_flush_pend <= 1'b0;
         r_flush_idx  <= '0;
         r_hit_cnt    <= '0;
         r_miss_cnt   <= '0;
         for (int s = 0; s < SETS; s++)
            r_valid[s] <= '0;
      end else begin
         r_state <= w_next;
         if (w_flush_start)
            r_flush_pend <= 1'b0;
         else if (flush)
            r_flush_pend <= 1'b1;
         if (w_flush_start)
            r_flush_idx <= '0;
         else if (w_clr_en)
            r_flush_idx <= r_flush_idx + IB'(1);
         if (w_hit_inc && (r_hit_cnt != 32'hFFFF_FFFF))
            r_hit_cnt <= r_hit_cnt + 32'd1;
         if (w_miss_inc && (r_miss_cnt != 32'hFFFF_FFFF))
            r_miss_cnt <= r_miss_cnt + 32'd1;
         if (w_clr_en)
            r_valid[r_flush_idx] <= '0;
         if (w_fill_en)
            r_valid[w_idx][w_victim] <= 1'b1;
      end
   end

   // Tag and data need no reset: valid bits gate every use of them.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (w_fill_en) begin
            r_tag[w_idx][w_victim] <= w_tag;
            for (int k = 0; k < LINE_WORDS; k++)
               r_data[w_idx][w_victim][k] <= sram_read_data[k*DATA_W +: DATA_W];
         end
         if (w_wr_hit_en)
            r_data[w_idx][w_hit_way][w_word] <= write_data;
      end
   end

   assign hit_count  = r_hit_cnt;
   assign miss_count = r_miss_cnt;

endmodule

// File: tb/tb_assoc_cache_ctrl.sv
// Directed and lightly randomised bench for assoc_cache_ctrl with a
// behavioural SRAM responder and a reference memory model.
module tb_assoc_cache_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] addr, write_data;
   logic        MEM_R_EN, MEM_W_EN, flush;
   logic [31:0] read_data;
   logic        ready;
   logic [31:0] sram_addr, sram_write_data;
   logic        sram_write_en, sram_read_en;
   logic [63:0] sram_read_data = '0;
   logic        sram_ready = 1'b0;
   logic [31:0] hit_count, miss_count;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];
   int exp_hits = 0;
   int exp_misses = 0;
   int sram_lat = 1;
   int sram_cnt = 0;
   logic [31:0] ref_mem[int];
   logic [31:0] sram_mem[int];

   assoc_cache_ctrl dut (
      .clk             (clk),
      .rst             (rst),
      .addr            (addr),
      .write_data      (write_data),
      .MEM_R_EN        (MEM_R_EN),
      .MEM_W_EN        (MEM_W_EN),
      .flush           (flush),
      .read_data       (read_data),
      .ready           (ready),
      .sram_addr       (sram_addr),
      .sram_write_data (sram_write_data),
      .sram_write_en   (sram_write_en),
      .sram_read_en    (sram_read_en),
      .sram_read_data  (sram_read_data),
      .sram_ready      (sram_ready),
      .hit_count       (hit_count),
      .miss_count      (miss_count)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] dflt(input logic [31:0] a);
      return {a[15:0], 16'hC0DE} ^ 32'h5A5A_0000;
   endfunction

   function automatic logic [31:0] ref_word(input logic [31:0] a);
      if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
      return dflt(a);
   endfunction

   function automatic logic [31:0] sram_word(input logic [31:0] a);
      if (sram_mem.exists(int'(a))) return sram_mem[int'(a)];
      return dflt(a);
   endfunction

   // SRAM responder: answers after sram_lat cycles with a one-cycle sram_ready.
   always @(negedge clk) begin
      if (rst) begin
         sram_ready = 1'b0;
         sram_cnt   = 0;
      end else if (sram_ready) begin
         sram_ready = 1'b0;
         sram_cnt   = 0;
      end else if (sram_read_en || sram_write_en) begin
         sram_cnt++;
         if (sram_cnt >= sram_lat) begin
            sram_ready = 1'b1;
            if (sram_write_en)
               sram_mem[int'(sram_addr)] = sram_write_data;
            else
               for (int k = 0; k < 2; k++)
                  sram_read_data[k*32 +: 32] = sram_word(sram_addr + 32'(4*k));
         end
      end else begin
         sram_cnt = 0;
      end
   end

   task automatic do_read(input logic [31:0] a, input int exp_hit);
      int n;
      logic [31:0] e;
      exp_q.push_back(ref_word(a));
      if (exp_hit == 1) exp_hits++;
      else if (exp_hit == 0) exp_misses++;
      addr = a; MEM_R_EN = 1'b1; MEM_W_EN = 1'b0;
      n = 0;
      #1;
      while (!ready && n < 100) begin
         @(negedge clk); #1; n++;
      end
      e = exp_q.pop_front();
      checks++;
      if (!ready) begin
         errors++;
         $display("FAIL read_timeout addr=%h ready=%b required ready=1", a, ready);
      end else begin
         if (read_data !== e) begin
            errors++;
            $display("FAIL read_data addr=%h got=%h required=%h", a, read_data, e);
         end
         if (exp_hit >= 0) begin
            checks++;
            if ((n == 0) !== (exp_hit == 1)) begin
               errors++;
               $display("FAIL hit_miss addr=%h wait_cycles=%0d required_hit=%0d", a, n, exp_hit);
            end
         end
         if (n > 0) begin
            checks++;
            if (sram_read_en !== 1'b1 || sram_write_en !== 1'b0 || sram_addr !== (a & ~32'h7)) begin
               errors++;
               $display("FAIL fill_strobe addr=%h rd_en=%b wr_en=%b sram_addr=%h required 1/0/%h", a, sram_read_en, sram_write_en, sram_addr, a & ~32'h7);
            end
         end
      end
      @(negedge clk);
      MEM_R_EN = 1'b0;
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic both);
      int n;
      ref_mem[int'(a)] = d;
      addr = a; write_data = d; MEM_W_EN = 1'b1; MEM_R_EN = both;
      n = 0;
      #1;
      while (!ready && n < 100) begin
         @(negedge clk); #1; n++;
      end
      checks++;
      if (!ready || n == 0) begin
         errors++;
         $display("FAIL write_done addr=%h ready=%b wait_cycles=%0d required ready after >=1 cycle", a, ready, n);
      end else begin
         checks++;
         if (sram_write_en !== 1'b1 || sram_read_en !== 1'b0 || sram_addr !== a || sram_write_data !== d) begin
            errors++;
            $display("FAIL write_strobe wr_en=%b rd_en=%b sram_addr=%h data=%h required 1/0/%h/%h", sram_write_en, sram_read_en, sram_addr, sram_write_data, a, d);
         end
      end
      @(negedge clk);
      MEM_W_EN = 1'b0; MEM_R_EN = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (ready !== 1'b1 || sram_read_en !== 1'b0 || sram_write_en !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs ready=%b rd_en=%b wr_en=%b required 1/0/0", ready, sram_read_en, sram_write_en);
      end
      checks++;
      if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
         errors++;
         $display("FAIL reset_counters hits=%0d misses=%0d required 0/0", hit_count, miss_count);
      end
      @(negedge clk);
   endtask

   task automatic test_read_miss_hit();
      sram_mem[32'h40] = 32'h0000_AAAA; ref_mem[32'h40] = 32'h0000_AAAA;
      sram_mem[32'h44] = 32'h0000_BBBB; ref_mem[32'h44] = 32'h0000_BBBB;
      sram_lat = 3;
      do_read(32'h40, 0);
      do_read(32'h44, 1);
      #1;
      checks++;
      if (hit_count !== 32'(exp_hits) || miss_count !== 32'(exp_misses)) begin
         errors++;
         $display("FAIL counters_miss_hit hits=%0d misses=%0d required %0d/%0d", hit_count, miss_count, exp_hits, exp_misses);
      end
      @(negedge clk);
   endtask

   task automatic test_write_hit();
      sram_lat = 2;
      do_write(32'h40, 32'h0000_1234, 1'b0);
      do_read(32'h40, 1);
      checks++;
      if (sram_mem[32'h40] !== 32'h0000_1234) begin
         errors++;
         $display("FAIL write_through sram=%h required=%h", sram_mem[32'h40], 32'h0000_1234);
      end
   endtask

   task automatic test_lru();
      sram_lat = 1;
      do_read(32'h000, 0);
      do_read(32'h200, 0);
      do_read(32'h000, 1);
      do_read(32'h400, 0);
      do_read(32'h200, 0);
      do_read(32'h400, 1);
      #1;
      checks++;
      if (hit_count !== 32'(exp_hits) || miss_count !== 32'(exp_misses)) begin
         errors++;
         $display("FAIL counters_lru hits=%0d misses=%0d required %0d/%0d", hit_count, miss_count, exp_hits, exp_misses);
      end
      @(negedge clk);
   endtask

   task automatic test_flush();
      int low;
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      low = 0;
      #1;
      while (!ready && low < 200) begin
         low++; @(negedge clk); #1;
      end
      checks++;
      if (low != 64) begin
         errors++;
         $display("FAIL flush_length low_cycles=%0d required=64", low);
      end
      @(negedge clk);
      do_read(32'h40, 0);
      do_read(32'h200, 0);
      do_read(32'h400, 0);
      // Flush raised together with a read: the read is served first.
      flush = 1'b1;
      do_read(32'h40, 1);
      flush = 1'b0;
      @(negedge clk);
      low = 0;
      #1;
      while (!ready && low < 200) begin
         low++; @(negedge clk); #1;
      end
      checks++;
      if (low != 64) begin
         errors++;
         $display("FAIL flush_pending_length low_cycles=%0d required=64", low);
      end
      @(negedge clk);
      do_read(32'h40, 0);
   endtask

   task automatic test_reset_mid_miss();
      sram_lat = 1;
      do_read(32'h80, 0);
      sram_lat = 10;
      addr = 32'hC0; MEM_R_EN = 1'b1;
      @(negedge clk); @(negedge clk); #1;
      checks++;
      if (sram_read_en !== 1'b1 || ready !== 1'b0) begin
         errors++;
         $display("FAIL mid_miss_state rd_en=%b ready=%b required 1/0", sram_read_en, ready);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; MEM_R_EN = 1'b0;
      #1;
      exp_hits = 0; exp_misses = 0;
      checks++;
      if (ready !== 1'b1 || sram_read_en !== 1'b0 || sram_write_en !== 1'b0 || hit_count !== 32'd0 || miss_count !== 32'd0) begin
         errors++;
         $display("FAIL reset_mid_miss ready=%b rd_en=%b wr_en=%b hits=%0d misses=%0d required 1/0/0/0/0", ready, sram_read_en, sram_write_en, hit_count, miss_count);
      end
      @(negedge clk);
      sram_lat = 2;
      do_read(32'h80, 0);
   endtask

   task automatic test_rw_both();
      do_write(32'h80, 32'hDEAD_BEEF, 1'b1);
      #1;
      checks++;
      if (hit_count !== 32'(exp_hits) || miss_count !== 32'(exp_misses)) begin
         errors++;
         $display("FAIL rw_both_uncounted hits=%0d misses=%0d required %0d/%0d", hit_count, miss_count, exp_hits, exp_misses);
      end
      @(negedge clk);
      do_read(32'h80, 1);
   endtask

   task automatic test_back_to_back();
      logic [31:0] base;
      int w;
      for (int i = 0; i < 6; i++) begin
         base = 32'h1000 + 32'(i * 8);
         for (int k = 0; k < 2; k++) begin
            sram_mem[int'(base) + 4*k] = $urandom;
            ref_mem[int'(base) + 4*k]  = sram_mem[int'(base) + 4*k];
         end
         sram_lat = $urandom_range(1, 4);
         w = $urandom_range(0, 1);
         do_read(base + 32'(4*w), 0);
         do_read(base + 32'(4*(1-w)), 1);
      end
      #1;
      checks++;
      if (hit_count !== 32'(exp_hits) || miss_count !== 32'(exp_misses)) begin
         errors++;
         $display("FAIL counters_final hits=%0d misses=%0d required %0d/%0d", hit_count, miss_count, exp_hits, exp_misses);
      end
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; addr = '0; write_data = '0;
      MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; flush = 1'b0;
      test_reset();
      test_read_miss_hit();
      test_write_hit();
      test_lru();
      test_flush();
      test_reset_mid_miss();
      test_rw_both();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout time=%0t required completion", $time);
      $fatal(1, "bench timeout");
   end

endmodule
